// File: rtl/rowcache_miss_sched_pkg.sv
// Shared types and widths for the row-cache miss scheduler.
// Holds the FSM encoding, DMA command and latched-miss bundles.
package rowcache_pkg;

  localparam int NREQ      = 4;
  localparam int CHWIDTH   = 5;
  localparam int ADDRWIDTH = 17;
  localparam int HADDRW    = 64;
  localparam int ROWB_LOG2 = 13;
  localparam int GIDW      = $clog2(NREQ);
  localparam int SLOTW     = GIDW + CHWIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [HADDRW-1:0] addr;
    logic [SLOTW-1:0]  slot;
  } dma_cmd_t;

  typedef struct packed {
    logic [ADDRWIDTH-1:0] row;
    logic [CHWIDTH-1:0]   slot;
    logic [ADDRWIDTH-1:0] vic_row;
  } miss_req_t;

  function automatic logic [HADDRW-1:0] row_addr(
    input logic [HADDRW-1:0]    base,
    input logic [GIDW-1:0]      gid,
    input logic [ADDRWIDTH-1:0] row
  );
    logic [HADDRW-1:0] line;
    line = HADDRW'({gid, row});
    return base + (line << ROWB_LOG2);
  endfunction

endpackage

// File: rtl/rowcache_miss_sched_if.sv
// Host DMA command port: valid/ready command plus done pulse.
// The scheduler is master; the DMA engine is slave.
interface rowcache_miss_sched_if;
  import rowcache_pkg::*;

  logic              dma_valid;
  logic              dma_ready;
  logic              dma_wr;
  logic [HADDRW-1:0] dma_addr;
  logic [SLOTW-1:0]  dma_slot;
  logic              dma_done;

  modport master (
    output dma_valid, dma_wr, dma_addr, dma_slot,
    input  dma_ready, dma_done
  );

  modport slave (
    input  dma_valid, dma_wr, dma_addr, dma_slot,
    output dma_ready, dma_done
  );

endinterface

// File: rtl/rowcache_miss_sched_rr_arbiter.sv
// Round-robin pick: first request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] id,
  output logic                    any
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0] idx;
  logic          hit;

  // scan from ptr upward; power-of-2 NREQ makes idx wrap for free
  always_comb begin
    gnt = '0;
    id  = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + GW'(i);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rowcache_miss_sched.sv
// Shared miss handler: arbitrates bank misses, issues optional
// victim write-back then row fill over one DMA port, then syncs.
module rowcache_miss_sched
  import rowcache_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*ADDRWIDTH-1:0] req_row,
  input  logic [NREQ*CHWIDTH-1:0]   req_slot,
  input  logic [NREQ-1:0]           req_vic_valid,
  input  logic [NREQ-1:0]           req_vic_dirty,
  input  logic [NREQ*ADDRWIDTH-1:0] req_vic_row,
  output logic [NREQ-1:0]           sync,
  output logic                      busy,
  output logic [GIDW-1:0]           grant_id,
  input  logic [HADDRW-1:0]         host_base,
  rowcache_miss_sched_if.master     dma,
  output logic [31:0]               miss_cnt,
  output logic [31:0]               wb_cnt
);

  state_t          st, nxt;
  logic [NREQ-1:0] gnt;
  logic [GIDW-1:0] arb_id;
  logic [GIDW-1:0] gid_q;
  logic [GIDW-1:0] ptr_q;
  logic            any;
  logic            wb_need;
  miss_req_t       sel;
  miss_req_t       mr_q;
  dma_cmd_t        cmd;
  logic [31:0]     miss_cnt_q;
  logic [31:0]     wb_cnt_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .id  (arb_id),
    .any (any)
  );

  // mux the granted bank's request fields
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.row     = req_row[i*ADDRWIDTH +: ADDRWIDTH];
        sel.slot    = req_slot[i*CHWIDTH +: CHWIDTH];
        sel.vic_row = req_vic_row[i*ADDRWIDTH +: ADDRWIDTH];
      end
    end
  end

  assign wb_need = |(gnt & req_vic_valid & req_vic_dirty);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:      if (any) nxt = wb_need ? WB_REQ : FILL_REQ;
      WB_REQ:    if (dma.dma_ready) nxt = WB_WAIT;
      WB_WAIT:   if (dma.dma_done) nxt = FILL_REQ;
      FILL_REQ:  if (dma.dma_ready) nxt = FILL_WAIT;
      FILL_WAIT: if (dma.dma_done) nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // capture the granted request; bank inputs are ignored afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mr_q  <= '0;
      gid_q <= '0;
      ptr_q <= '0;
    end else if (st == IDLE && any) begin
      mr_q  <= sel;
      gid_q <= arb_id;
      ptr_q <= arb_id + GIDW'(1);
    end
  end

  // saturating service counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (st == WB_REQ && dma.dma_ready && wb_cnt_q != '1)
        wb_cnt_q <= wb_cnt_q + 32'd1;
      if (st == DONE && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // command and sync outputs, decoded from state
  always_comb begin
    cmd  = '0;
    sync = '0;
    unique case (st)
      WB_REQ: begin
        cmd.wr   = 1'b1;
        cmd.addr = row_addr(host_base, gid_q, mr_q.vic_row);
        cmd.slot = {gid_q, mr_q.slot};
      end
      FILL_REQ: begin
        cmd.wr   = 1'b0;
        cmd.addr = row_addr(host_base, gid_q, mr_q.row);
        cmd.slot = {gid_q, mr_q.slot};
      end
      DONE:    sync[gid_q] = 1'b1;
      default: ;
    endcase
  end

  assign dma.dma_valid = (st == WB_REQ) || (st == FILL_REQ);
  assign dma.dma_wr    = cmd.wr;
  assign dma.dma_addr  = cmd.addr;
  assign dma.dma_slot  = cmd.slot;
  assign busy          = (st != IDLE);
  assign grant_id      = gid_q;
  assign miss_cnt      = miss_cnt_q;
  assign wb_cnt        = wb_cnt_q;

endmodule
